room_scroll_ctrl: RTL and testbench

- Controller that sequences room-to-room background transitions for the VGA background path (room ROM + palette lookup).
- Accepts a transition request from game logic, then advances a per-frame scroll offset.
- Drives current/next room select to the background address generator, which blends the two rooms by offset.
- Freezes player logic for the duration; swaps the current room and pulses done at the end.

---
 rtl/room_scroll_ctrl.sv | 147 ++++++++++++++
 tb/tb_room_scroll_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/room_scroll_ctrl.sv
// Room-to-room background transition sequencer: accepts a request, scrolls
// one step per frame toward the new room, holds, then swaps the current room.
module room_scroll_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int STEP_X      = 16,
  parameter int STEP_Y      = 12,
  parameter int HOLD_FRAMES = 2,
  parameter int START_ROOM  = 0
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       req_valid,
  input  logic [1:0] req_dir,
  input  logic [3:0] req_room,
  output logic       req_ready,
  output logic [3:0] cur_room,
  output logic [3:0] next_room,
  output logic [1:0] scroll_dir,
  output logic [9:0] scroll_off,
  output logic       active,
  output logic       done
);

  localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [9:0]    STEP_X_V = 10'(STEP_X);
  localparam logic [9:0]    STEP_Y_V = 10'(STEP_Y);
  localparam logic [9:0]    LIM_X_V  = 10'(SCREEN_W);
  localparam logic [9:0]    LIM_Y_V  = 10'(SCREEN_H);
  localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_FRAMES);
  localparam logic [3:0]    START_V  = 4'(START_ROOM);

  typedef enum logic [2:0] {IDLE, ARM, SCROLL, SETTLE, FINISH} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    cur_d, next_d;
  logic [1:0]    dir_d;
  logic [9:0]    off_d;
  logic          active_d, done_d, ready_d;

  logic [9:0]  step, limit;
  logic [10:0] sum;

  // Vertical directions (1x) use the Y step/limit, horizontal (0x) the X ones.
  assign step  = scroll_dir[1] ? STEP_Y_V : STEP_X_V;
  assign limit = scroll_dir[1] ? LIM_Y_V  : LIM_X_V;
  assign sum   = {1'b0, scroll_off} + {1'b0, step};

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      cur_room   <= START_V;
      next_room  <= START_V;
      scroll_dir <= 2'b00;
      scroll_off <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cur_room   <= cur_d;
      next_room  <= next_d;
      scroll_dir <= dir_d;
      scroll_off <= off_d;
      active     <= active_d;
      done       <= done_d;
      req_ready  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cur_d    = cur_room;
    next_d   = next_room;
    dir_d    = scroll_dir;
    off_d    = scroll_off;
    active_d = active;
    done_d   = 1'b0;
    ready_d  = req_ready;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          next_d   = req_room;
          dir_d    = req_dir;
          active_d = 1'b1;
          ready_d  = 1'b0;
          if (req_room == cur_room) begin
            state_d = FINISH;
            done_d  = 1'b1;
            cur_d   = req_room;
            off_d   = '0;
          end else begin
            state_d = ARM;
          end
        end
      end

      // scroll_off is 0 in ARM, so the shared adder yields exactly one step.
      ARM, SCROLL: begin
        if (frame_start) begin
          if (sum >= {1'b0, limit}) begin
            off_d   = limit;
            hold_d  = HOLD_V;
            state_d = SETTLE;
          end else begin
            off_d   = sum[9:0];
            state_d = SCROLL;
          end
        end
      end

      SETTLE: begin
        if (frame_start) begin
          if (hold_q <= HW'(1)) begin
            hold_d  = '0;
            state_d = FINISH;
            done_d  = 1'b1;
            cur_d   = next_room;
            off_d   = '0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end

      FINISH: begin
        state_d  = IDLE;
        active_d = 1'b0;
        ready_d  = 1'b1;
      end

      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
        ready_d  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_room_scroll_ctrl.sv
// Directed bench for room_scroll_ctrl: a default instance plus a HOLD_FRAMES=1
// instance driven by the same stimulus.
module tb_room_scroll_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_dir = 2'b00;
  logic [3:0] req_room = 4'd0;

  logic       req_ready, active, done;
  logic [3:0] cur_room, next_room;
  logic [1:0] scroll_dir;
  logic [9:0] scroll_off;

  logic       req_ready_b, active_b, done_b;
  logic [3:0] cur_room_b, next_room_b;
  logic [1:0] scroll_dir_b;
  logic [9:0] scroll_off_b;

  int checks = 0;
  int failures = 0;

  room_scroll_ctrl u_dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
    .req_valid(req_valid), .req_dir(req_dir), .req_room(req_room),
    .req_ready(req_ready), .cur_room(cur_room), .next_room(next_room),
    .scroll_dir(scroll_dir), .scroll_off(scroll_off),
    .active(active), .done(done)
  );

  room_scroll_ctrl #(.HOLD_FRAMES(1)) u_dut_h1 (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
    .req_valid(req_valid), .req_dir(req_dir), .req_room(req_room),
    .req_ready(req_ready_b), .cur_room(cur_room_b), .next_room(next_room_b),
    .scroll_dir(scroll_dir_b), .scroll_off(scroll_off_b),
    .active(active_b), .done(done_b)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int   frame_no;
    int   exp_off;
    logic exp_active;
    logic exp_done;
    int   exp_cur;
  } vec_t;

  vec_t tbl[7];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // One idle cycle, then a frame_start edge; returns just after that edge.
  task automatic pulse_frame();
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic apply_stimulus(input logic [1:0] dir, input logic [3:0] room);
    req_valid = 1'b1;
    req_dir   = dir;
    req_room  = room;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int fcount;

    tbl[0] = '{1,  16,  1'b1, 1'b0, 0};
    tbl[1] = '{2,  32,  1'b1, 1'b0, 0};
    tbl[2] = '{20, 320, 1'b1, 1'b0, 0};
    tbl[3] = '{39, 624, 1'b1, 1'b0, 0};
    tbl[4] = '{40, 640, 1'b1, 1'b0, 0};
    tbl[5] = '{41, 640, 1'b1, 1'b0, 0};
    tbl[6] = '{42, 0,   1'b1, 1'b1, 5};

    do_reset();
    check_output("rst_ready", int'(req_ready), 1);
    check_output("rst_cur", int'(cur_room), 0);
    check_output("rst_next", int'(next_room), 0);
    check_output("rst_off", int'(scroll_off), 0);
    check_output("rst_active", int'(active), 0);

    // Left scroll 0 -> 5 on the default instance
    apply_stimulus(2'b00, 4'd5);
    check_output("left_ready", int'(req_ready), 0);
    check_output("left_active", int'(active), 1);
    check_output("left_next", int'(next_room), 5);
    fcount = 0;
    for (int i = 0; i < 7; i++) begin
      while (fcount < tbl[i].frame_no) begin
        pulse_frame();
        fcount++;
      end
      check_output($sformatf("left_off_f%0d", tbl[i].frame_no), int'(scroll_off), tbl[i].exp_off);
      check_output($sformatf("left_active_f%0d", tbl[i].frame_no), int'(active), int'(tbl[i].exp_active));
      check_output($sformatf("left_done_f%0d", tbl[i].frame_no), int'(done), int'(tbl[i].exp_done));
      check_output($sformatf("left_cur_f%0d", tbl[i].frame_no), int'(cur_room), tbl[i].exp_cur);
    end
    step();
    check_output("left_done_after", int'(done), 0);
    check_output("left_active_after", int'(active), 0);
    check_output("left_ready_after", int'(req_ready), 1);

    // Down scroll 5 -> 9 on the HOLD_FRAMES=1 instance
    check_output("down_cur_start", int'(cur_room_b), 5);
    apply_stimulus(2'b11, 4'd9);
    check_output("down_dir", int'(scroll_dir_b), 3);
    pulse_frame();
    check_output("down_off_f1", int'(scroll_off_b), 12);
    pulse_frame();
    check_output("down_off_f2", int'(scroll_off_b), 24);
    for (int i = 3; i <= 40; i++) pulse_frame();
    check_output("down_off_f40", int'(scroll_off_b), 480);
    check_output("down_done_f40", int'(done_b), 0);
    pulse_frame();
    check_output("down_done_f41", int'(done_b), 1);
    check_output("down_cur_f41", int'(cur_room_b), 9);
    check_output("down_off_f41", int'(scroll_off_b), 0);
    step();
    check_output("down_done_after", int'(done_b), 0);
    check_output("down_active_after", int'(active_b), 0);

    // Asynchronous reset in the middle of a scroll
    do_reset();
    apply_stimulus(2'b00, 4'd5);
    for (int i = 0; i < 20; i++) pulse_frame();
    check_output("mid_off", int'(scroll_off), 320);
    #3;
    Reset = 1'b1;
    #1;
    check_output("async_off", int'(scroll_off), 0);
    check_output("async_active", int'(active), 0);
    check_output("async_cur", int'(cur_room), 0);
    check_output("async_ready", int'(req_ready), 1);
    check_output("async_done", int'(done), 0);
    step();
    Reset = 1'b0;
    step();
    check_output("post_rst_done", int'(done), 0);
    check_output("post_rst_next", int'(next_room), 0);

    // frame_start coincident with accept must not count
    req_valid   = 1'b1;
    req_dir     = 2'b00;
    req_room    = 4'd4;
    frame_start = 1'b1;
    step();
    req_valid   = 1'b0;
    frame_start = 1'b0;
    check_output("coin_off_accept", int'(scroll_off), 0);
    check_output("coin_active", int'(active), 1);
    step();
    check_output("coin_off_idle", int'(scroll_off), 0);
    pulse_frame();
    check_output("coin_off_f1", int'(scroll_off), 16);

    // Right scroll 0 -> 3, then a same-room request
    do_reset();
    apply_stimulus(2'b01, 4'd3);
    check_output("right_dir", int'(scroll_dir), 1);
    for (int i = 0; i < 42; i++) pulse_frame();
    check_output("right_done", int'(done), 1);
    step();
    check_output("right_cur", int'(cur_room), 3);
    apply_stimulus(2'b10, 4'd3);
    check_output("same_done", int'(done), 1);
    check_output("same_off", int'(scroll_off), 0);
    check_output("same_cur", int'(cur_room), 3);
    step();
    check_output("same_done_after", int'(done), 0);
    check_output("same_active_after", int'(active), 0);
    check_output("same_ready_after", int'(req_ready), 1);

    // Request held while busy is ignored, then accepted once idle
    do_reset();
    apply_stimulus(2'b00, 4'd2);
    for (int i = 0; i < 5; i++) pulse_frame();
    req_valid = 1'b1;
    req_dir   = 2'b01;
    req_room  = 4'd7;
    step();
    check_output("busy_ready", int'(req_ready), 0);
    check_output("busy_next", int'(next_room), 2);
    for (int i = 5; i < 42; i++) pulse_frame();
    check_output("busy_done", int'(done), 1);
    check_output("busy_cur", int'(cur_room), 2);
    step();
    check_output("busy_idle_ready", int'(req_ready), 1);
    step();
    req_valid = 1'b0;
    check_output("busy_accept_next", int'(next_room), 7);
    check_output("busy_accept_dir", int'(scroll_dir), 1);
    check_output("busy_accept_active", int'(active), 1);
    check_output("busy_accept_ready", int'(req_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
